// File: rtl/bus_pkg.sv
// Shared definitions for the peripheral bus decoder: widths, FSM state type,
// default peripheral address windows and a small index-width helper.
package bus_pkg;

    localparam int unsigned BUS_AW = 32;
    localparam int unsigned BUS_DW = 32;
    localparam int unsigned BUS_SW = 2;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } bus_state_e;

    // Default peripheral windows for top-level instantiation.
    localparam logic [BUS_AW-1:0] GPU_BASE  = 32'hFFC0_0000;
    localparam logic [BUS_AW-1:0] GPU_MASK  = 32'hFFC0_0000;
    localparam logic [BUS_AW-1:0] UART_BASE = 32'hFFFF_F000;
    localparam logic [BUS_AW-1:0] UART_MASK = 32'hFFFF_F800;
    localparam logic [BUS_AW-1:0] PS2_BASE  = 32'hFFFF_FC00;
    localparam logic [BUS_AW-1:0] PS2_MASK  = 32'hFFFF_FFFF;

    // Width of a slave index; never zero so single-slave builds still elaborate.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_decoder_if.sv
// Bus bundle between the CPU data port, the decoder and the peripherals.
interface bus_decoder_if
    import bus_pkg::*;
#(
    parameter int unsigned N_SLAVES = 4
) ();

    logic [BUS_AW-1:0]          m_addr_i;
    logic [BUS_DW-1:0]          m_data_i;
    logic [BUS_SW-1:0]          m_sel_i;
    logic                       m_rd_i;
    logic                       m_we_i;
    logic [BUS_DW-1:0]          m_data_o;
    logic                       m_ack_o;
    logic                       m_err_o;

    logic [BUS_AW-1:0]          s_addr_o;
    logic [BUS_DW-1:0]          s_data_o;
    logic [BUS_SW-1:0]          s_sel_o;
    logic [N_SLAVES-1:0]        s_rd_o;
    logic [N_SLAVES-1:0]        s_we_o;
    logic [BUS_DW*N_SLAVES-1:0] s_data_i;
    logic [N_SLAVES-1:0]        s_ack_i;

    // CPU side: issues requests, receives completions.
    modport master (
        output m_addr_i, m_data_i, m_sel_i, m_rd_i, m_we_i,
        input  m_data_o, m_ack_o, m_err_o
    );

    // Peripheral side: receives strobes, returns data and acknowledges.
    modport slave (
        input  s_addr_o, s_data_o, s_sel_o, s_rd_o, s_we_o,
        output s_data_i, s_ack_i
    );

    // The decoder sits between both sides.
    modport decoder (
        input  m_addr_i, m_data_i, m_sel_i, m_rd_i, m_we_i,
        output m_data_o, m_ack_o, m_err_o,
        output s_addr_o, s_data_o, s_sel_o, s_rd_o, s_we_o,
        input  s_data_i, s_ack_i
    );

endinterface

// File: rtl/bus_addr_decode.sv
// Combinational address match against per-slave base/mask windows; the
// lowest-index matching slave wins.
module bus_addr_decode
    import bus_pkg::*;
#(
    parameter int unsigned                    N_SLAVES = 4,
    parameter logic [BUS_AW*N_SLAVES-1:0]     SLV_BASE = {N_SLAVES{32'h0}},
    parameter logic [BUS_AW*N_SLAVES-1:0]     SLV_MASK = {N_SLAVES{32'hFFFF_FFFF}},
    localparam int unsigned                   IdxW     = idx_width(N_SLAVES)
) (
    input  logic [BUS_AW-1:0] addr,
    output logic              hit,
    output logic [IdxW-1:0]   idx
);

    // Scan from the top so the lowest-index match is the last one written.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[BUS_AW*i +: BUS_AW]) ==
                (SLV_BASE[BUS_AW*i +: BUS_AW] & SLV_MASK[BUS_AW*i +: BUS_AW])) begin
                hit = 1'b1;
                idx = IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/bus_decoder.sv
// Single-master, N-slave bus decoder: registers a master request, strobes the
// selected slave until it acknowledges (or times out), then returns a
// one-cycle ack, with err flagged for unmapped addresses and timeouts.
module bus_decoder
    import bus_pkg::*;
#(
    parameter int unsigned                N_SLAVES = 4,
    parameter logic [BUS_AW*N_SLAVES-1:0] SLV_BASE = {N_SLAVES{32'h0}},
    parameter logic [BUS_AW*N_SLAVES-1:0] SLV_MASK = {N_SLAVES{32'hFFFF_FFFF}},
    parameter int unsigned                TIMEOUT  = 255
) (
    input  logic           clk,
    input  logic           rst,
    bus_decoder_if.decoder bus
);

    localparam int unsigned IdxW = idx_width(N_SLAVES);
    // One bit minimum so a disabled timeout still has a (saturating) counter.
    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

    bus_state_e state_q, state_d;

    logic [IdxW-1:0]     idx_q, idx_d;
    logic                we_q, we_d;
    logic                err_q, err_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [BUS_AW-1:0]   addr_q, addr_d;
    logic [BUS_DW-1:0]   wdata_q, wdata_d;
    logic [BUS_SW-1:0]   sel_q, sel_d;
    logic [BUS_DW-1:0]   rdata_q, rdata_d;
    logic                ack_q, ack_d;
    logic                merr_q, merr_d;
    logic [N_SLAVES-1:0] s_rd_q, s_rd_d;
    logic [N_SLAVES-1:0] s_we_q, s_we_d;

    logic            dec_hit;
    logic [IdxW-1:0] dec_idx;
    logic            req;
    logic            sel_ack;
    logic            timeout;

    bus_addr_decode #(
        .N_SLAVES (N_SLAVES),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_addr_decode (
        .addr (bus.m_addr_i),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

    assign req     = bus.m_rd_i | bus.m_we_i;
    assign sel_ack = bus.s_ack_i[idx_q];
    assign timeout = (TIMEOUT != 0) && (cnt_q == TimeoutCnt);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an ack in the same cycle as the timeout wins.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (req) state_d = dec_hit ? StAccess : StDone;
            StAccess: if (sel_ack || timeout) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Next values of the latched command and of every registered output.
    always_comb begin
        idx_d   = idx_q;
        we_d    = we_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        merr_d  = 1'b0;
        s_rd_d  = '0;
        s_we_d  = '0;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    addr_d  = bus.m_addr_i;
                    wdata_d = bus.m_data_i;
                    sel_d   = bus.m_sel_i;
                    we_d    = bus.m_we_i;  // rd+we together is a write
                    idx_d   = dec_idx;
                    cnt_d   = '0;
                    if (!dec_hit) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end
            end
            StAccess: begin
                if (sel_ack) begin
                    rdata_d = bus.s_data_i[BUS_DW*idx_q +: BUS_DW];
                    err_d   = 1'b0;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase

        if (state_d == StDone) begin
            ack_d  = 1'b1;
            merr_d = err_d;
        end

        if (state_d == StAccess) begin
            if (we_d) begin
                s_we_d[idx_d] = 1'b1;
            end else begin
                s_rd_d[idx_d] = 1'b1;
            end
        end
    end

    // Datapath and output registers; reset drops any in-flight access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            merr_q  <= 1'b0;
            s_rd_q  <= '0;
            s_we_q  <= '0;
        end else begin
            idx_q   <= idx_d;
            we_q    <= we_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            merr_q  <= merr_d;
            s_rd_q  <= s_rd_d;
            s_we_q  <= s_we_d;
        end
    end

    assign bus.m_data_o = rdata_q;
    assign bus.m_ack_o  = ack_q;
    assign bus.m_err_o  = merr_q;
    assign bus.s_addr_o = addr_q;
    assign bus.s_data_o = wdata_q;
    assign bus.s_sel_o  = sel_q;
    assign bus.s_rd_o   = s_rd_q;
    assign bus.s_we_o   = s_we_q;

endmodule

// File: tb/tb_bus_decoder.sv
// Directed self-checking bench for bus_decoder. Four slaves:
//   0: FFC0_0000 / FFF0_0000   1: FFFF_F000 / FFFF_F800
//   2: FFFF_FC00 / FFFF_FFFF   3: FFC0_0000 / FFC0_0000 (wide window
//   overlapping 0 and 2, so priority is exercised). TIMEOUT = 4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_bus_decoder;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bus_decoder_if #(.N_SLAVES(4)) bus ();

    bus_decoder #(
        .N_SLAVES (4),
        .SLV_BASE ({32'hFFC0_0000, 32'hFFFF_FC00, 32'hFFFF_F000, 32'hFFC0_0000}),
        .SLV_MASK ({32'hFFC0_0000, 32'hFFFF_FFFF, 32'hFFFF_F800, 32'hFFF0_0000}),
        .TIMEOUT  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_master();
        bus.m_rd_i = 1'b0;
        bus.m_we_i = 1'b0;
    endtask

    initial begin
        bus.m_addr_i = '0;
        bus.m_data_i = '0;
        bus.m_sel_i  = '0;
        bus.m_rd_i   = 1'b0;
        bus.m_we_i   = 1'b0;
        bus.s_data_i = '0;
        bus.s_ack_i  = '0;

        // Reset state.
        #3;
        check("rst_ack",   32'(bus.m_ack_o),  32'h0);
        check("rst_err",   32'(bus.m_err_o),  32'h0);
        check("rst_rd",    32'(bus.s_rd_o),   32'h0);
        check("rst_we",    32'(bus.s_we_o),   32'h0);
        check("rst_mdata", bus.m_data_o,      32'h0);
        cyc();
        rst = 1'b1;
        cyc();

        // A: read slave 2, immediate ack.
        bus.m_addr_i = 32'hFFFF_FC00;
        bus.m_rd_i   = 1'b1;
        bus.s_data_i[64 +: 32] = 32'hA5A5_0001;
        cyc();
        check("a_c1_rd",   32'(bus.s_rd_o),  32'h4);
        check("a_c1_ack",  32'(bus.m_ack_o), 32'h0);
        check("a_c1_addr", bus.s_addr_o,     32'hFFFF_FC00);
        bus.s_ack_i = 4'b0100;
        cyc();
        check("a_c2_ack",  32'(bus.m_ack_o), 32'h1);
        check("a_c2_err",  32'(bus.m_err_o), 32'h0);
        check("a_c2_data", bus.m_data_o,     32'hA5A5_0001);
        check("a_c2_rd",   32'(bus.s_rd_o),  32'h0);
        idle_master();
        bus.s_ack_i = '0;
        cyc();
        check("a_c3_ack",  32'(bus.m_ack_o), 32'h0);

        // B: write slave 0 (slave 3 also matches), ack after 3 strobe cycles;
        // a stray ack from slave 3 must be ignored.
        bus.m_addr_i = 32'hFFC0_0010;
        bus.m_data_i = 32'h0000_1234;
        bus.m_sel_i  = 2'b10;
        bus.m_we_i   = 1'b1;
        bus.s_data_i[0 +: 32] = 32'hDEAD_0000;
        cyc();
        check("b_c1_we",   32'(bus.s_we_o),  32'h1);
        check("b_c1_rd",   32'(bus.s_rd_o),  32'h0);
        check("b_c1_data", bus.s_data_o,     32'h0000_1234);
        check("b_c1_sel",  32'(bus.s_sel_o), 32'h2);
        bus.s_ack_i = 4'b1000;
        cyc();
        check("b_c2_we",   32'(bus.s_we_o),  32'h1);
        check("b_c2_ack",  32'(bus.m_ack_o), 32'h0);
        bus.s_ack_i = '0;
        cyc();
        check("b_c3_we",   32'(bus.s_we_o),  32'h1);
        check("b_c3_ack",  32'(bus.m_ack_o), 32'h0);
        bus.s_ack_i = 4'b0001;
        cyc();
        check("b_c4_ack",  32'(bus.m_ack_o), 32'h1);
        check("b_c4_err",  32'(bus.m_err_o), 32'h0);
        check("b_c4_we",   32'(bus.s_we_o),  32'h0);
        idle_master();
        bus.s_ack_i = '0;
        cyc();

        // C: unmapped read.
        bus.m_addr_i = 32'h0000_0100;
        bus.m_rd_i   = 1'b1;
        cyc();
        check("c_c1_ack",  32'(bus.m_ack_o), 32'h1);
        check("c_c1_err",  32'(bus.m_err_o), 32'h1);
        check("c_c1_data", bus.m_data_o,     32'h0);
        check("c_c1_rd",   32'(bus.s_rd_o),  32'h0);
        idle_master();
        cyc();
        check("c_c2_ack",  32'(bus.m_ack_o), 32'h0);
        check("c_c2_rd",   32'(bus.s_rd_o),  32'h0);

        // E: address only slave 3 decodes.
        bus.m_addr_i = 32'hFFD0_0000;
        bus.m_rd_i   = 1'b1;
        bus.s_data_i[96 +: 32] = 32'h3333_CAFE;
        cyc();
        check("e_c1_rd",   32'(bus.s_rd_o),  32'h8);
        bus.s_ack_i = 4'b1000;
        cyc();
        check("e_c2_ack",  32'(bus.m_ack_o), 32'h1);
        check("e_c2_data", bus.m_data_o,     32'h3333_CAFE);
        idle_master();
        bus.s_ack_i = '0;
        cyc();

        // D: slave 1 never acks -> strobe cycles 1..5, ack+err in cycle 6.
        bus.m_addr_i = 32'hFFFF_F000;
        bus.m_rd_i   = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            cyc();
            check($sformatf("d_c%0d_rd", c),  32'(bus.s_rd_o),  32'h2);
            check($sformatf("d_c%0d_ack", c), 32'(bus.m_ack_o), 32'h0);
        end
        cyc();
        check("d_c6_ack",  32'(bus.m_ack_o), 32'h1);
        check("d_c6_err",  32'(bus.m_err_o), 32'h1);
        check("d_c6_data", bus.m_data_o,     32'h0);
        check("d_c6_rd",   32'(bus.s_rd_o),  32'h0);
        idle_master();
        cyc();
        check("d_c7_ack",  32'(bus.m_ack_o), 32'h0);

        // F: rd and we together is a write; then G: back-to-back request
        // presented during DONE is taken after one idle cycle.
        bus.m_addr_i = 32'hFFFF_FC00;
        bus.m_data_i = 32'h0000_5555;
        bus.m_rd_i   = 1'b1;
        bus.m_we_i   = 1'b1;
        cyc();
        check("f_c1_we",   32'(bus.s_we_o),  32'h4);
        check("f_c1_rd",   32'(bus.s_rd_o),  32'h0);
        bus.s_ack_i = 4'b0100;
        cyc();
        check("f_c2_ack",  32'(bus.m_ack_o), 32'h1);
        bus.s_ack_i  = '0;
        bus.m_we_i   = 1'b0;
        bus.s_data_i[64 +: 32] = 32'h6666_0002;
        cyc();
        check("g_c3_rd",   32'(bus.s_rd_o),  32'h0);
        check("g_c3_ack",  32'(bus.m_ack_o), 32'h0);
        cyc();
        check("g_c4_rd",   32'(bus.s_rd_o),  32'h4);
        bus.s_ack_i = 4'b0100;
        cyc();
        check("g_c5_ack",  32'(bus.m_ack_o), 32'h1);
        check("g_c5_data", bus.m_data_o,     32'h6666_0002);
        idle_master();
        bus.s_ack_i = '0;
        cyc();

        // H: asynchronous reset in the middle of an access.
        bus.m_addr_i = 32'hFFFF_F000;
        bus.m_rd_i   = 1'b1;
        cyc();
        check("h_c1_rd",   32'(bus.s_rd_o),  32'h2);
        #2;
        rst = 1'b0;
        #1;
        check("h_rst_rd",    32'(bus.s_rd_o),  32'h0);
        check("h_rst_addr",  bus.s_addr_o,     32'h0);
        check("h_rst_mdata", bus.m_data_o,     32'h0);
        check("h_rst_ack",   32'(bus.m_ack_o), 32'h0);
        idle_master();
        cyc();
        rst = 1'b1;
        cyc();
        check("h_post_ack",  32'(bus.m_ack_o), 32'h0);
        bus.m_addr_i = 32'hFFFF_FC00;
        bus.m_rd_i   = 1'b1;
        bus.s_data_i[64 +: 32] = 32'h0BAD_F00D;
        cyc();
        check("h_c1b_rd",  32'(bus.s_rd_o),  32'h4);
        bus.s_ack_i = 4'b0100;
        cyc();
        check("h_c2b_ack",  32'(bus.m_ack_o), 32'h1);
        check("h_c2b_err",  32'(bus.m_err_o), 32'h0);
        check("h_c2b_data", bus.m_data_o,     32'h0BAD_F00D);
        idle_master();
        bus.s_ack_i = '0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bus_decoder.md
# bus_decoder

Parametrised single-master, N-slave memory-mapped bus decoder that replaces fixed per-peripheral address decoding in the SoC's peripheral bus. It registers each master request, routes it to exactly one slave selected by per-slave base/mask parameters, and waits for that slave's acknowledge. It also returns an error response for unmapped addresses and for slaves that fail to acknowledge within a timeout. It sits between the CPU data port and the peripherals (GPU, UART, PS/2, and later additions).

## Interface
- `N_SLAVES`, 4: number of slave ports (1..16).
- `SLV_BASE`, {N_SLAVES{32'h0}}: flattened 32-bit base address per slave; slave i occupies bits [32*i+31:32*i].
- `SLV_MASK`, {N_SLAVES{32'hFFFF_FFFF}}: flattened 32-bit compare mask per slave; slave i matches when (addr & mask_i) == (base_i & mask_i).
- `TIMEOUT`, 255: ACCESS cycles without ack before an error is returned; 0 disables the timeout.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low.
- `m_addr_i`  in  32  master address.
- `m_data_i`  in  32  master write data.
- `m_sel_i`  in  2  master access size/select, passed through.
- `m_rd_i` / `m_we_i`  in  1  master read / write request; held until `m_ack_o`.
- `m_data_o`  out  32  registered read data.
- `m_ack_o`  out  1  one-cycle completion pulse.
- `m_err_o`  out  1  qualifies `m_ack_o`; 1 = unmapped address or timeout.
- `s_addr_o`  out  32  latched address, shared by all slaves.
- `s_data_o`  out  32  latched write data, shared.
- `s_sel_o`  out  2  latched select, shared.
- `s_rd_o` / `s_we_o`  out  N_SLAVES  per-slave read / write strobes; one-hot or zero.
- `s_data_i`  in  32*N_SLAVES  flattened slave read data.
- `s_ack_i`  in  N_SLAVES  per-slave acknowledge.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: when `m_rd_i | m_we_i` is set, latch addr/data/sel/rd/we and decode.
  - When one or more slaves match, the lowest-index match wins; latch its index, clear the counter, and go to ACCESS.
  - When no slave matches, set err and go to DONE.
  - If both `m_rd_i` and `m_we_i` are set, treat the access as a write.
- ACCESS: drive `s_rd_o[idx]` or `s_we_o[idx]` from the latched command; all other strobe bits are 0.
  - When `s_ack_i[idx]` is high, capture `s_data_i[idx]` into `m_data_o` (writes capture too; the value is don't-care), clear err, and go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT (TIMEOUT≠0), set err, set `m_data_o` = 32'h0, and go to DONE.
  - Ack on the same cycle as timeout: the ack wins.
- DONE: `m_ack_o`=1 and `m_err_o`=err for exactly one cycle; strobes are 0; go to IDLE.
- Ack on a non-selected slave: ignored.
- The master must drop or change its request in the cycle after `m_ack_o`; any request seen in IDLE is a new transaction.
- Counter width: $clog2(TIMEOUT+1); it saturates and never wraps.
- Reset (any state, including mid-ACCESS): state=IDLE; all `s_*_o`, `m_data_o`, `m_ack_o`, `m_err_o` = 0; the aborted slave access is dropped without a response.

## Timing
- All outputs are registered; there is no combinational path from `m_*_i` or `s_*_i` to any output.
- Request sampled at edge 0, so slave strobes are visible in cycle 1.
- Slave acks in its first strobe cycle: `m_ack_o` in cycle 2 (minimum latency 2).
- Slave acks after k strobe cycles: `m_ack_o` at cycle k+1.
- Unmapped address: `m_ack_o`+`m_err_o` in cycle 1.
- Timeout: `m_ack_o`+`m_err_o` in cycle TIMEOUT+2 after the request edge.
- Back-to-back: a new request is accepted in the cycle after DONE, giving 1 idle-state cycle minimum between transactions.

## Structure
- Shared package `bus_pkg`:
  - state enum {IDLE, ACCESS, DONE};
  - constants BUS_AW=32, BUS_DW=32, BUS_SW=2;
  - default GPU/UART/PS2 base/mask constants for top-level instantiation.
- Sub-module `bus_addr_decode`: combinational, parametrised by N_SLAVES/SLV_BASE/SLV_MASK; outputs `hit` and a priority-encoded `idx`.

## Test plan
- N_SLAVES=3, bases 32'hFFC0_0000/32'hFFFF_F000/32'hFFFF_FC00, masks FFC0_0000/FFFF_F800/FFFF_FFFF.
  - Read 32'hFFFF_FC00 with slave 2 acking immediately, data 32'hA5A5_0001 -> `s_rd_o`=3'b100 in cycle 1; `m_ack_o`=1, `m_data_o`=32'hA5A5_0001, `m_err_o`=0 in cycle 2.
  - Write 32'hFFC0_0010, data 32'h1234, slave 0 acks after 3 cycles -> `s_we_o`=3'b001 held 3 cycles; `s_data_o`=32'h1234; `m_ack_o` at cycle 4.
- Read 32'h0000_0100 (unmapped) -> no strobe ever; `m_ack_o`=`m_err_o`=1 in cycle 1; `m_data_o`=0.
- TIMEOUT=4, slave never acks -> strobe high for cycles 1..5; ack+err at cycle 6; then IDLE.
- Overlapping masks matching slaves 0 and 1 -> only `s_rd_o[0]` asserted; `s_ack_i[1]` pulses ignored.
- Assert `rst`=0 mid-ACCESS -> all outputs 0 immediately (asynchronously); after release, a fresh read completes normally with 2-cycle latency.
